// File: rtl/conv_gemm_pkg.sv
// Shared definitions for the convolution-as-GEMM datapath: controller state
// encoding and the K/P size derivations, also used by the im2col stage.
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_MAC    = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4
    } conv_state_e;

    // Reduction length: one GEMM row spans a full kernel window over all channels
    function automatic int conv_k(input int filter_size, input int channels);
        return filter_size * filter_size * channels;
    endfunction

    // Output pixels per filter (stride 1, same-size output)
    function automatic int conv_p(input int img_w, input int img_h);
        return img_w * img_h;
    endfunction

endpackage

// File: rtl/conv_gemm_if.sv
// Memory-side bus of conv_gemm: one read port with one-cycle latency and a
// write port strobed once per result.
interface conv_gemm_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 32
);
    logic        [ADDR_WIDTH-1:0] addr_rd;
    logic signed [DATA_WIDTH-1:0] data_rd;
    logic        [ADDR_WIDTH-1:0] addr_wr;
    logic signed [OUT_WIDTH-1:0]  data_wr;
    logic                         mem_wr_en;

    modport master (
        output addr_rd,
        input  data_rd,
        output addr_wr,
        output data_wr,
        output mem_wr_en
    );

    modport slave (
        input  addr_rd,
        output data_rd,
        input  addr_wr,
        input  data_wr,
        input  mem_wr_en
    );
endinterface

// File: rtl/conv_gemm_mac.sv
// Signed multiply-accumulate with synchronous clear and enable; exposes the
// value the accumulator takes on the coming edge so results can be registered.
module conv_mac #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [OUT_WIDTH-1:0]  acc_next
);
    logic signed [2*DATA_WIDTH-1:0] prod_s;
    logic signed [OUT_WIDTH-1:0]    prod_ext_s;
    logic signed [OUT_WIDTH-1:0]    acc_s;
    logic signed [OUT_WIDTH-1:0]    acc_r;

    assign prod_s     = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
    assign prod_ext_s = OUT_WIDTH'(prod_s);

    // Next accumulator value: clear wins over accumulate; sum wraps
    always_comb begin
        acc_s = acc_r;
        if (clr) begin
            acc_s = '0;
        end else if (en) begin
            acc_s = acc_r + prod_ext_s;
        end else begin
            acc_s = acc_r;
        end
    end

    // Accumulator register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= '0;
        end else begin
            acc_r <= acc_s;
        end
    end

    assign acc_next = acc_s;

endmodule

// File: rtl/conv_gemm.sv
// Convolution layer as GEMM over an im2col matrix: buffers one filter's
// weights, then streams each pixel's patch through a MAC and writes the result.
module conv_gemm
    import conv_pkg::*;
#(
    parameter int          IMG_C       = 1,
    parameter int          IMG_W       = 8,
    parameter int          IMG_H       = 8,
    parameter int          FILTER_SIZE = 3,
    parameter int          FILTER_NUM  = 2,
    parameter int          DATA_WIDTH  = 8,
    parameter int          OUT_WIDTH   = 32,
    parameter int          ADDR_WIDTH  = 32,
    parameter logic [15:0] IM2COL_BASE = 16'h2000,
    parameter logic [15:0] WEIGHT_BASE = 16'h4000,
    parameter logic [15:0] OUTPUT_BASE = 16'h6000,
    parameter int          ADDR_STRIDE = DATA_WIDTH,
    parameter int          OUT_STRIDE  = OUT_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        done,
    conv_gemm_if.master mem
);
    localparam int K     = conv_k(FILTER_SIZE, IMG_C);
    localparam int P     = conv_p(IMG_W, IMG_H);
    localparam int CNT_W = $clog2(K + 1);
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
    localparam int P_W   = (P > 1) ? $clog2(P) : 1;
    localparam int F_W   = (FILTER_NUM > 1) ? $clog2(FILTER_NUM) : 1;

    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(K);
    localparam logic [P_W-1:0]   P_LAST = P_W'(P - 1);
    localparam logic [F_W-1:0]   F_LAST = F_W'(FILTER_NUM - 1);

    conv_state_e state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [P_W-1:0]   p_r, p_s;
    logic [F_W-1:0]   f_r, f_s;
    logic [IDX_W-1:0] idx_s;
    logic mac_en_s, mac_clr_s, wbuf_we_s, wr_s;

    logic        [ADDR_WIDTH-1:0] addr_rd_r, addr_rd_s;
    logic        [ADDR_WIDTH-1:0] addr_wr_r;
    logic signed [OUT_WIDTH-1:0]  data_wr_r;
    logic signed [OUT_WIDTH-1:0]  acc_next_s;
    logic                         mem_wr_en_r;
    logic                         done_r;
    logic signed [DATA_WIDTH-1:0] wbuf_r [K];

    function automatic logic [ADDR_WIDTH-1:0] elem_addr(input logic [15:0] base,
                                                        input int row, input int len,
                                                        input int col, input int stride);
        return ADDR_WIDTH'(base) + ADDR_WIDTH'((row * len + col) * stride);
    endfunction

    // Data for the address issued on count c arrives on count c+1
    assign idx_s = IDX_W'(cnt_r - CNT_W'(1'b1));

    // Next-state and datapath control
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        p_s       = p_r;
        f_s       = f_r;
        mac_en_s  = 1'b0;
        mac_clr_s = 1'b0;
        wbuf_we_s = 1'b0;
        wr_s      = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s = ST_LOAD_W;
                    cnt_s   = '0;
                    p_s     = '0;
                    f_s     = '0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_LOAD_W: begin
                wbuf_we_s = (cnt_r != '0);
                if (cnt_r == K_LAST) begin
                    state_s = ST_MAC;
                    cnt_s   = '0;
                    p_s     = '0;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1'b1);
                end
            end
            ST_MAC: begin
                mac_en_s = (cnt_r != '0);
                if (cnt_r == K_LAST) begin
                    state_s = ST_WRITE;
                    cnt_s   = '0;
                    wr_s    = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1'b1);
                end
            end
            ST_WRITE: begin
                mac_clr_s = 1'b1;
                if (p_r != P_LAST) begin
                    state_s = ST_MAC;
                    p_s     = p_r + P_W'(1'b1);
                end else if (f_r != F_LAST) begin
                    state_s = ST_LOAD_W;
                    f_s     = f_r + F_W'(1'b1);
                    p_s     = '0;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Read address for the coming cycle; holds once a sweep has issued all K
    always_comb begin
        addr_rd_s = addr_rd_r;
        if (state_s == ST_LOAD_W && cnt_s != K_LAST) begin
            addr_rd_s = elem_addr(WEIGHT_BASE, int'(f_s), K, int'(cnt_s), ADDR_STRIDE);
        end else if (state_s == ST_MAC && cnt_s != K_LAST) begin
            addr_rd_s = elem_addr(IM2COL_BASE, int'(p_s), K, int'(cnt_s), ADDR_STRIDE);
        end else begin
            addr_rd_s = addr_rd_r;
        end
    end

    // Controller state and registered bus outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            p_r         <= '0;
            f_r         <= '0;
            addr_rd_r   <= ADDR_WIDTH'(IM2COL_BASE);
            addr_wr_r   <= ADDR_WIDTH'(OUTPUT_BASE);
            data_wr_r   <= '0;
            mem_wr_en_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            p_r         <= p_s;
            f_r         <= f_s;
            addr_rd_r   <= addr_rd_s;
            mem_wr_en_r <= wr_s;
            // done trails entry into DONE by one cycle and drops on restart
            done_r      <= (state_r == ST_DONE) && !start;
            if (wr_s) begin
                addr_wr_r <= elem_addr(OUTPUT_BASE, int'(f_r), P, int'(p_r), OUT_STRIDE);
                data_wr_r <= acc_next_s;
            end
        end
    end

    // Weight buffer, contents meaningful only after LOAD_W
    always_ff @(posedge clk) begin
        if (wbuf_we_s) begin
            wbuf_r[idx_s] <= mem.data_rd;
        end
    end

    conv_mac #(
        .DATA_WIDTH(DATA_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .clr     (mac_clr_s),
        .en      (mac_en_s),
        .a       (wbuf_r[idx_s]),
        .b       (mem.data_rd),
        .acc_next(acc_next_s)
    );

    assign mem.addr_rd   = addr_rd_r;
    assign mem.addr_wr   = addr_wr_r;
    assign mem.data_wr   = data_wr_r;
    assign mem.mem_wr_en = mem_wr_en_r;
    assign done          = done_r;

endmodule

// File: tb/tb_conv_gemm.sv
// Bench for conv_gemm: 4x4x1 image, 3x3 kernel, 2 filters, run on a 32-bit and
// a 16-bit result DUT in lockstep against a plain-arithmetic GEMM model.
module tb_conv_gemm;
    localparam int KK  = 9;
    localparam int PP  = 16;
    localparam int FN  = 2;
    localparam int XB  = 32'h2000;
    localparam int WB  = 32'h4000;
    localparam int OB  = 32'h6000;
    localparam int LAT = 373;

    typedef struct {
        logic        [31:0] a32;
        logic        [31:0] a16;
        logic signed [31:0] d32;
        logic signed [15:0] d16;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic done32, done16;

    conv_gemm_if #(.ADDR_WIDTH(32), .DATA_WIDTH(8), .OUT_WIDTH(32)) bus32 ();
    conv_gemm_if #(.ADDR_WIDTH(32), .DATA_WIDTH(8), .OUT_WIDTH(16)) bus16 ();

    conv_gemm #(.IMG_C(1), .IMG_W(4), .IMG_H(4), .FILTER_SIZE(3), .FILTER_NUM(2),
                .DATA_WIDTH(8), .OUT_WIDTH(32), .ADDR_WIDTH(32))
        dut32 (.clk(clk), .rst(rst), .start(start), .done(done32), .mem(bus32));
    conv_gemm #(.IMG_C(1), .IMG_W(4), .IMG_H(4), .FILTER_SIZE(3), .FILTER_NUM(2),
                .DATA_WIDTH(8), .OUT_WIDTH(16), .ADDR_WIDTH(32))
        dut16 (.clk(clk), .rst(rst), .start(start), .done(done16), .mem(bus16));

    always #5 clk = ~clk;

    logic signed [7:0] xmem [PP][KK];
    logic signed [7:0] wmem [FN][KK];
    exp_t   exp32_q[$], exp16_q[$];
    longint log32_d[$], log16_d[$], prev_d[$];
    longint log32_a[$], prev_a[$];
    int checks = 0, failures = 0;
    int wr_cnt32 = 0, wr_cnt16 = 0;
    int lat;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic logic [7:0] mem_read(input logic [31:0] a);
        int ai, off;
        ai = int'(a);
        if (ai >= XB && ai < XB + PP*KK*8) begin
            off = (ai - XB) / 8;
            return xmem[off / KK][off % KK];
        end else if (ai >= WB && ai < WB + FN*KK*8) begin
            off = (ai - WB) / 8;
            return wmem[off / KK][off % KK];
        end else begin
            return 8'h00;
        end
    endfunction

    // memory with one-cycle read latency for each DUT
    always @(posedge clk) begin
        bus32.data_rd <= mem_read(bus32.addr_rd);
        bus16.data_rd <= mem_read(bus16.addr_rd);
    end

    // Reference GEMM: result(f,p) = sum_k W(f,k)*X(p,k), in write order
    task automatic build_expect();
        exp32_q.delete();
        exp16_q.delete();
        for (int f = 0; f < FN; f++) begin
            for (int p = 0; p < PP; p++) begin
                longint s;
                exp_t e;
                s = 0;
                for (int k = 0; k < KK; k++) s += longint'(wmem[f][k]) * longint'(xmem[p][k]);
                e.a32 = 32'(OB + (f*PP + p) * 32);
                e.a16 = 32'(OB + (f*PP + p) * 16);
                e.d32 = s[31:0];
                e.d16 = s[15:0];
                exp32_q.push_back(e);
                exp16_q.push_back(e);
            end
        end
    endtask

    // every write from either DUT is checked against the model in order
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus32.mem_wr_en) begin
            wr_cnt32++;
            log32_d.push_back(longint'(bus32.data_wr));
            log32_a.push_back(longint'(bus32.addr_wr));
            if (exp32_q.size() == 0) begin
                chk("unexpected_wr32", longint'(bus32.addr_wr), -1);
            end else begin
                e = exp32_q.pop_front();
                chk("wr_addr32", longint'(bus32.addr_wr), longint'(e.a32));
                chk("wr_data32", longint'(bus32.data_wr), longint'(e.d32));
            end
        end
        if (!rst && bus16.mem_wr_en) begin
            wr_cnt16++;
            log16_d.push_back(longint'(bus16.data_wr));
            if (exp16_q.size() == 0) begin
                chk("unexpected_wr16", longint'(bus16.addr_wr), -1);
            end else begin
                e = exp16_q.pop_front();
                chk("wr_addr16", longint'(bus16.addr_wr), longint'(e.a16));
                chk("wr_data16", longint'(bus16.data_wr), longint'(e.d16));
            end
        end
    end

    task automatic clear_logs();
        log32_d.delete(); log16_d.delete(); log32_a.delete();
        wr_cnt32 = 0; wr_cnt16 = 0;
    endtask

    task automatic check_reset_vals();
        chk("rst_done", longint'(done32), 0);
        chk("rst_wr_en", longint'(bus32.mem_wr_en), 0);
        chk("rst_data_wr", longint'(bus32.data_wr), 0);
        chk("rst_addr_rd", longint'(bus32.addr_rd), XB);
        chk("rst_addr_wr", longint'(bus32.addr_wr), OB);
        chk("rst_wr_en16", longint'(bus16.mem_wr_en), 0);
        chk("rst_data_wr16", longint'(bus16.data_wr), 0);
    endtask

    // start for 'hold' cycles, measure edges from start sample to done rise
    task automatic run_layer(input int hold);
        build_expect();
        clear_logs();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        if (hold <= 1) start = 1'b0;
        chk("done_cleared", longint'(done32), 0);
        lat = 0;
        while (done32 !== 1'b1 && lat < 2000) begin
            @(negedge clk);
            lat++;
            if (lat == hold) start = 1'b0;
        end
        start = 1'b0;
        chk("latency", lat, LAT);
        chk("done16", longint'(done16), 1);
        chk("wr_count32", wr_cnt32, 32);
        chk("wr_count16", wr_cnt16, 32);
        chk("missing_wr", exp32_q.size() + exp16_q.size(), 0);
        repeat (3) @(negedge clk);
        chk("done_held", longint'(done32), 1);
        chk("idle_wr_en", longint'(bus32.mem_wr_en), 0);
        chk("no_extra_wr", wr_cnt32, 32);
    endtask

    task automatic fill(input int xv, input int wv);
        for (int p = 0; p < PP; p++) for (int k = 0; k < KK; k++) xmem[p][k] = 8'(xv);
        for (int f = 0; f < FN; f++) for (int k = 0; k < KK; k++) wmem[f][k] = 8'(wv);
    endtask

    task automatic check_all_nines();
        for (int i = 0; i < log32_d.size(); i++) begin
            chk("ones_data32", log32_d[i], 9);
            chk("ones_addr32", log32_a[i], OB + i*32);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        fill(1, 1);
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // all ones
        run_layer(1);
        check_all_nines();

        // most negative operands: 9*16384 wraps in 16 bits
        fill(-128, -128);
        run_layer(1);
        for (int i = 0; i < log32_d.size(); i++) chk("neg_data32", log32_d[i], 147456);
        for (int i = 0; i < log16_d.size(); i++) chk("neg_data16", log16_d[i], 16384);

        // single centre tap picks X(p,4)
        fill(0, 0);
        wmem[0][4] = 8'sd1;
        for (int p = 0; p < PP; p++) for (int k = 0; k < KK; k++) xmem[p][k] = 8'(p*KK + k);
        run_layer(1);
        for (int i = 0; i < log32_d.size(); i++) begin
            int v;
            v = (i < PP) ? i*9 + 4 : 0;
            if (v > 127) v = v - 256;
            chk("tap_data32", log32_d[i], v);
        end

        // random operands against the model
        repeat (2) begin
            for (int p = 0; p < PP; p++) for (int k = 0; k < KK; k++) xmem[p][k] = 8'($urandom_range(0, 255));
            for (int f = 0; f < FN; f++) for (int k = 0; k < KK; k++) wmem[f][k] = 8'($urandom_range(0, 255));
            run_layer(1);
        end

        // reset in the middle of pixel 5, filter 0
        fill(1, 1);
        build_expect();
        clear_logs();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (70) @(negedge clk);
        chk("wr_before_rst", wr_cnt32, 5);
        rst = 1'b1;
        exp32_q.delete();
        exp16_q.delete();
        @(negedge clk);
        check_reset_vals();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("no_wr_after_rst", wr_cnt32, 5);
        check_reset_vals();
        run_layer(1);
        check_all_nines();

        // start held through a run, then re-pulsed in DONE
        for (int p = 0; p < PP; p++) for (int k = 0; k < KK; k++) xmem[p][k] = 8'($urandom_range(0, 255));
        for (int f = 0; f < FN; f++) for (int k = 0; k < KK; k++) wmem[f][k] = 8'($urandom_range(0, 255));
        run_layer(100);
        prev_d = log32_d;
        prev_a = log32_a;
        run_layer(1);
        chk("rerun_len", log32_d.size(), prev_d.size());
        for (int i = 0; i < log32_d.size() && i < prev_d.size(); i++) begin
            chk("rerun_data", log32_d[i], prev_d[i]);
            chk("rerun_addr", log32_a[i], prev_a[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
